// File: rtl/ps2_pkg.sv
// PS/2 keyboard constants and types shared by the key event generator.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package ps2_pkg;

   // Prefix and sequence bytes that never produce an event on their own
   localparam logic [7:0] PS2_EXT   = 8'hE0;
   localparam logic [7:0] PS2_REL   = 8'hF0;
   localparam logic [7:0] PS2_PAUSE = 8'hE1;

   // Bytes left over from the 8-byte Pause sequence after its E1 header
   localparam logic [2:0] PAUSE_SKIP = 3'd7;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } ps2_bit_state_t;

   // Device status/ack bytes (self-test, echo, ack, resend, errors) carry no key
   function automatic logic is_non_key(input logic [7:0] b);
      logic r;
      case (b)
         8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: r = 1'b1;
         default:                                           r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ps2_key_event_gen_if.sv
// PS/2 pins in, key event bus and frame error pulse out.
// Latency: n/a (signal bundle only).
// Backpressure: none; events are strobed by toggling ps2_key[10].
interface ps2_key_event_gen_if;
   logic        ps2_clk;
   logic        ps2_data;
   logic [10:0] ps2_key;
   logic        frame_err;

   // Side that drives the PS/2 lines and watches events (keyboard model / pins)
   modport master (
      output ps2_clk,
      output ps2_data,
      input  ps2_key,
      input  frame_err
   );

   // Side that decodes the lines and publishes events
   modport slave (
      input  ps2_clk,
      input  ps2_data,
      output ps2_key,
      output frame_err
   );
endinterface

// File: rtl/ps2_line_filter.sv
// Synchronizes both PS/2 lines, deglitches the clock and flags its falling edges.
// Latency: fall_stb 2 sync + FILT_LEN filter + 1 cycles after the raw clock falls.
// Backpressure: none; a pulse is produced for every accepted falling edge.
module ps2_line_filter #(
   parameter int FILT_LEN = 8
) (
   input  logic clk_sys,
   input  logic reset,
   input  logic ps2_clk,
   input  logic ps2_data,
   output logic fall_stb,
   output logic data_s
);

   localparam int FCW = $clog2(FILT_LEN + 1);

   logic [1:0]     clk_sync_q;
   logic [1:0]     data_sync_q;
   logic           filt_q;
   logic [FCW-1:0] cnt_q;
   logic           fall_q;

   // Two-flop synchronizers; both lines idle high so they reset to 1
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         clk_sync_q  <= 2'b11;
         data_sync_q <= 2'b11;
      end else begin
         clk_sync_q  <= {clk_sync_q[0], ps2_clk};
         data_sync_q <= {data_sync_q[0], ps2_data};
      end
   end

   // Accept a new clock level only after FILT_LEN consecutive differing samples
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         filt_q <= 1'b1;
         cnt_q  <= '0;
         fall_q <= 1'b0;
      end else begin
         fall_q <= 1'b0;
         if (clk_sync_q[1] == filt_q) begin
            cnt_q <= '0;
         end else if (cnt_q == FCW'(FILT_LEN - 1)) begin
            filt_q <= clk_sync_q[1];
            cnt_q  <= '0;
            fall_q <= filt_q;   // only a 1->0 transition is an edge of interest
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign fall_stb = fall_q;
   assign data_s   = data_sync_q[1];

endmodule

// File: rtl/ps2_key_event_gen.sv
// Decodes PS/2 device frames and folds E0/F0/E1 sequences into toggle-strobed key events.
// Latency: ps2_key updates 1 cycle after the STOP bit is sampled on a filtered falling edge.
// Backpressure: none; consumers must compare ps2_key[10] against its previous value.
module ps2_key_event_gen
   import ps2_pkg::*;
#(
   parameter int FILT_LEN    = 8,
   parameter int TIMEOUT_CYC = 22000
) (
   input  logic                clk_sys,
   input  logic                reset,
   ps2_key_event_gen_if.slave  bus
);

   localparam int TCW = $clog2(TIMEOUT_CYC);

   logic           fall_stb;
   logic           data_s;

   ps2_bit_state_t state_q;
   logic [2:0]     bit_cnt_q;
   logic [7:0]     shift_q;
   logic           par_q;
   logic [TCW-1:0] to_q;
   logic           frame_err_q;
   logic           byte_vld_q;

   logic [10:0]    key_q;
   logic           ext_pend_q;
   logic           rel_pend_q;
   logic [2:0]     skip_cnt_q;

   ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_filter (
      .clk_sys  (clk_sys),
      .reset    (reset),
      .ps2_clk  (bus.ps2_clk),
      .ps2_data (bus.ps2_data),
      .fall_stb (fall_stb),
      .data_s   (data_s)
   );

   // Bit-level frame FSM with mid-frame timeout; a falling edge always beats the timeout
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         par_q       <= 1'b0;
         to_q        <= '0;
         frame_err_q <= 1'b0;
         byte_vld_q  <= 1'b0;
      end else begin
         frame_err_q <= 1'b0;
         byte_vld_q  <= 1'b0;
         if (fall_stb) begin
            to_q <= '0;
            case (state_q)
               IDLE: begin
                  if (!data_s) begin
                     state_q   <= DATA;
                     bit_cnt_q <= '0;
                  end else begin
                     frame_err_q <= 1'b1;
                  end
               end
               DATA: begin
                  shift_q   <= {data_s, shift_q[7:1]};
                  bit_cnt_q <= bit_cnt_q + 1'b1;
                  if (bit_cnt_q == 3'd7) state_q <= PARITY;
               end
               PARITY: begin
                  par_q   <= data_s;
                  state_q <= STOP;
               end
               STOP: begin
                  // shift_q stays stable until the next frame's data bits arrive
                  if (data_s && (^{shift_q, par_q})) byte_vld_q  <= 1'b1;
                  else                               frame_err_q <= 1'b1;
                  state_q <= IDLE;
               end
               default: state_q <= IDLE;
            endcase
         end else if (state_q != IDLE) begin
            if (to_q == TCW'(TIMEOUT_CYC - 1)) begin
               state_q     <= IDLE;
               frame_err_q <= 1'b1;
               to_q        <= '0;
            end else begin
               to_q <= to_q + 1'b1;
            end
         end else begin
            to_q <= '0;
         end
      end
   end

   // Byte layer: Pause skipping, prefix folding and event publication
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         key_q      <= '0;
         ext_pend_q <= 1'b0;
         rel_pend_q <= 1'b0;
         skip_cnt_q <= '0;
      end else if (frame_err_q) begin
         // a broken frame may have been a key byte; don't let stale prefixes attach to the next one
         ext_pend_q <= 1'b0;
         rel_pend_q <= 1'b0;
      end else if (byte_vld_q) begin
         if (skip_cnt_q != 3'd0) begin
            skip_cnt_q <= skip_cnt_q - 1'b1;
         end else if (shift_q == PS2_PAUSE) begin
            skip_cnt_q <= PAUSE_SKIP;
            ext_pend_q <= 1'b0;
            rel_pend_q <= 1'b0;
         end else if (shift_q == PS2_EXT) begin
            ext_pend_q <= 1'b1;
         end else if (shift_q == PS2_REL) begin
            rel_pend_q <= 1'b1;
         end else if (is_non_key(shift_q)) begin
            ext_pend_q <= 1'b0;
            rel_pend_q <= 1'b0;
         end else begin
            key_q      <= {~key_q[10], ~rel_pend_q, ext_pend_q, shift_q};
            ext_pend_q <= 1'b0;
            rel_pend_q <= 1'b0;
         end
      end
   end

   assign bus.ps2_key   = key_q;
   assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_key_event_gen.sv
// Self-checking bench: directed frame table, corner-case sequences, random frames vs a prefix-queue model.
// Latency: n/a.
// Backpressure: n/a.
module tb_ps2_key_event_gen;

   localparam int H = 16;   // PS/2 half bit period in clk_sys cycles

   logic clk_sys;
   logic reset;
   ps2_key_event_gen_if bus();

   ps2_key_event_gen #(.FILT_LEN(8), .TIMEOUT_CYC(22000)) dut (
      .clk_sys (clk_sys),
      .reset   (reset),
      .bus     (bus)
   );

   initial begin
      clk_sys = 1'b0;
      forever #5 clk_sys = ~clk_sys;
   end

   int tests;
   int failed;
   int cyc;
   int err_seen;
   int last_fall;

   always @(posedge clk_sys) cyc <= cyc + 1;

   // Count frame_err pulses, sampled away from the active edge
   always @(negedge clk_sys) begin
      if (!reset && bus.frame_err === 1'b1) err_seen = err_seen + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic ps2_bit(input logic b);
      @(negedge clk_sys);
      bus.ps2_data = b;
      repeat (H) @(negedge clk_sys);
      bus.ps2_clk = 1'b0;
      last_fall = cyc;
      repeat (H) @(negedge clk_sys);
      bus.ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] d, input bit flip, input bit stop);
      logic par;
      par = ~(^d) ^ flip;
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(d[i]);
      ps2_bit(par);
      ps2_bit(stop);
      @(negedge clk_sys);
      bus.ps2_data = 1'b1;
      repeat (4) @(negedge clk_sys);
   endtask

   typedef struct {
      logic [7:0]  data;
      bit          flip;
      bit          stop;
      logic [10:0] exp_key;
      int          exp_err;
   } vec_t;

   vec_t tbl[21];

   // Reference model: prefixes collected in a queue, applied to the next key byte
   logic [7:0]  pend_q[$];
   int          skip_m;
   bit          tog_m;
   logic [10:0] key_m;
   logic [7:0]  non_key[7];

   function automatic bit is_nk(input logic [7:0] b);
      foreach (non_key[i]) if (non_key[i] == b) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_byte(input logic [7:0] b, input bit bad);
      bit ext;
      bit rel;
      if (bad) begin
         pend_q.delete();
      end else if (skip_m > 0) begin
         skip_m--;
      end else if (b == 8'hE1) begin
         skip_m = 7;
         pend_q.delete();
      end else if (b == 8'hE0 || b == 8'hF0) begin
         pend_q.push_back(b);
      end else if (is_nk(b)) begin
         pend_q.delete();
      end else begin
         ext = 1'b0;
         rel = 1'b0;
         foreach (pend_q[i]) begin
            if (pend_q[i] == 8'hE0) ext = 1'b1;
            if (pend_q[i] == 8'hF0) rel = 1'b1;
         end
         tog_m = ~tog_m;
         key_m = {tog_m, ~rel, ext, b};
         pend_q.delete();
      end
   endtask

   initial begin
      int e0;
      int dt;
      logic [7:0] b;
      bit bad;

      tests = 0; failed = 0; cyc = 0; err_seen = 0; last_fall = 0;
      non_key = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};

      tbl[0]  = '{8'h1D, 0, 1, 11'h61D, 0};
      tbl[1]  = '{8'hE0, 0, 1, 11'h61D, 0};
      tbl[2]  = '{8'hF0, 0, 1, 11'h61D, 0};
      tbl[3]  = '{8'h6B, 0, 1, 11'h16B, 0};
      tbl[4]  = '{8'hE1, 0, 1, 11'h16B, 0};
      tbl[5]  = '{8'h14, 0, 1, 11'h16B, 0};
      tbl[6]  = '{8'h77, 0, 1, 11'h16B, 0};
      tbl[7]  = '{8'hE1, 0, 1, 11'h16B, 0};
      tbl[8]  = '{8'hF0, 0, 1, 11'h16B, 0};
      tbl[9]  = '{8'h14, 0, 1, 11'h16B, 0};
      tbl[10] = '{8'hF0, 0, 1, 11'h16B, 0};
      tbl[11] = '{8'h77, 0, 1, 11'h16B, 0};
      tbl[12] = '{8'h29, 0, 1, 11'h629, 0};
      tbl[13] = '{8'hE0, 0, 1, 11'h629, 0};
      tbl[14] = '{8'h29, 1, 1, 11'h629, 1};
      tbl[15] = '{8'h29, 0, 1, 11'h229, 0};
      tbl[16] = '{8'hAA, 0, 1, 11'h229, 0};
      tbl[17] = '{8'hF0, 0, 1, 11'h229, 0};
      tbl[18] = '{8'hFA, 0, 1, 11'h229, 0};
      tbl[19] = '{8'h1C, 0, 1, 11'h61C, 0};
      tbl[20] = '{8'h1D, 0, 0, 11'h61C, 1};

      bus.ps2_clk  = 1'b1;
      bus.ps2_data = 1'b1;
      reset = 1'b1;
      repeat (5) @(negedge clk_sys);
      check("reset_key", 32'(bus.ps2_key), 32'h0);
      check("reset_err", 32'(bus.frame_err), 32'h0);
      reset = 1'b0;
      repeat (5) @(negedge clk_sys);

      // Directed frame table
      for (int i = 0; i < 21; i++) begin
         e0 = err_seen;
         send_frame(tbl[i].data, tbl[i].flip, tbl[i].stop);
         check($sformatf("tbl%0d_key", i), 32'(bus.ps2_key), 32'(tbl[i].exp_key));
         check($sformatf("tbl%0d_err", i), 32'(err_seen - e0), 32'(tbl[i].exp_err));
      end

      // Start bit high is rejected
      e0 = err_seen;
      ps2_bit(1'b1);
      repeat (H) @(negedge clk_sys);
      check("badstart_err", 32'(err_seen - e0), 32'd1);
      check("badstart_key", 32'(bus.ps2_key), 32'h61C);

      // Short clock glitches with data low must not start a frame
      e0 = err_seen;
      bus.ps2_data = 1'b0;
      for (int g = 0; g < 12; g++) begin
         repeat (10) @(negedge clk_sys);
         bus.ps2_clk = 1'b0;
         repeat (3) @(negedge clk_sys);
         bus.ps2_clk = 1'b1;
      end
      repeat (20) @(negedge clk_sys);
      bus.ps2_data = 1'b1;
      send_frame(8'h1D, 0, 1);
      check("glitch_key", 32'(bus.ps2_key), 32'h21D);
      check("glitch_err", 32'(err_seen - e0), 32'd0);

      // Partial frame then idle: timeout fires near 22000 cycles after the last edge
      e0 = err_seen;
      dt = -1;
      ps2_bit(1'b0);
      for (int i = 0; i < 5; i++) ps2_bit(i[0]);
      for (int c = 0; c < 25000; c++) begin
         @(negedge clk_sys);
         if (dt < 0 && err_seen != e0) dt = cyc - last_fall;
      end
      check("timeout_seen", 32'(dt >= 0), 32'd1);
      check("timeout_window", 32'(dt >= 22000 && dt <= 22040), 32'd1);
      check("timeout_count", 32'(err_seen - e0), 32'd1);
      e0 = err_seen;
      send_frame(8'h1C, 0, 1);
      check("after_to_key", 32'(bus.ps2_key), 32'h61C);
      check("after_to_err", 32'(err_seen - e0), 32'd0);

      // Reset in the middle of the data bits
      ps2_bit(1'b0);
      for (int i = 0; i < 4; i++) ps2_bit(~i[0]);
      @(negedge clk_sys);
      reset = 1'b1;
      repeat (3) @(negedge clk_sys);
      check("midrst_key", 32'(bus.ps2_key), 32'h0);
      check("midrst_err", 32'(bus.frame_err), 32'h0);
      reset = 1'b0;
      bus.ps2_data = 1'b1;
      repeat (20) @(negedge clk_sys);
      e0 = err_seen;
      send_frame(8'h1D, 0, 1);
      check("postrst_key", 32'(bus.ps2_key), 32'h61D);
      check("postrst_err", 32'(err_seen - e0), 32'd0);

      // Randomized frames against the model
      reset = 1'b1;
      repeat (3) @(negedge clk_sys);
      reset = 1'b0;
      repeat (5) @(negedge clk_sys);
      pend_q.delete();
      skip_m = 0;
      tog_m = 1'b0;
      key_m = '0;
      for (int n = 0; n < 50; n++) begin
         case ($urandom_range(0, 15))
            0, 1, 2: b = 8'hE0;
            3, 4:    b = 8'hF0;
            5:       b = 8'hE1;
            6:       b = non_key[$urandom_range(0, 6)];
            default: b = 8'($urandom_range(0, 255));
         endcase
         bad = ($urandom_range(0, 9) == 0);
         e0 = err_seen;
         send_frame(b, bad, 1);
         model_byte(b, bad);
         check($sformatf("rnd%0d_key", n), 32'(bus.ps2_key), 32'(key_m));
         check($sformatf("rnd%0d_err", n), 32'(err_seen - e0), 32'(bad));
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
